// File: rtl/test_harness_monitor_if.sv
// Bus between a test harness and test_harness_monitor: run configuration and channel status in, verdict out.
// The stall-detection signals exist only when TEST_HARNESS_MONITOR_STALL_EN is defined.
interface test_harness_monitor_if #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 64
`ifdef TEST_HARNESS_MONITOR_STALL_EN
  , parameter int STALL_W = 16
`endif
);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [CNT_W-1:0] max_cycles;
  logic [CNT_W-1:0] dump_start;
  logic [N_CH-1:0]  ch_success;
  logic [N_CH-1:0]  ch_failure;
`ifdef TEST_HARNESS_MONITOR_STALL_EN
  logic [N_CH-1:0]    ch_progress;
  logic [STALL_W-1:0] stall_limit;
`endif

  logic             dut_reset;
  logic [CNT_W-1:0] cycle_count;
  logic             dump_en;
  logic             done;
  logic             pass;
  logic             fail;
  logic [1:0]       fail_reason;
  logic [CH_W-1:0]  fail_channel;
  logic [N_CH-1:0]  done_mask;

`ifdef TEST_HARNESS_MONITOR_STALL_EN
  modport master (
    output max_cycles, dump_start, ch_success, ch_failure, ch_progress, stall_limit,
    input  dut_reset, cycle_count, dump_en, done, pass, fail, fail_reason, fail_channel, done_mask
  );
  modport slave (
    input  max_cycles, dump_start, ch_success, ch_failure, ch_progress, stall_limit,
    output dut_reset, cycle_count, dump_en, done, pass, fail, fail_reason, fail_channel, done_mask
  );
`else
  modport master (
    output max_cycles, dump_start, ch_success, ch_failure,
    input  dut_reset, cycle_count, dump_en, done, pass, fail, fail_reason, fail_channel, done_mask
  );
  modport slave (
    input  max_cycles, dump_start, ch_success, ch_failure,
    output dut_reset, cycle_count, dump_en, done, pass, fail, fail_reason, fail_channel, done_mask
  );
`endif
endinterface

// File: rtl/test_harness_monitor.sv
// End-of-test monitor: sequences DUT reset, counts cycles, gates dumping and latches one pass/fail verdict.
// Optional per-channel stall detection is enabled by defining TEST_HARNESS_MONITOR_STALL_EN.
module test_harness_monitor #(
  parameter int N_CH         = 4,
  parameter int CNT_W        = 64,
  parameter int RESET_CYCLES = 16,
  parameter int STALL_W      = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  test_harness_monitor_if.slave bus
);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int HC_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(RESET_CYCLES - 1);

  if (N_CH < 1 || RESET_CYCLES < 1 || STALL_W < 1) begin : g_bad_param
    $error("test_harness_monitor: N_CH, RESET_CYCLES and STALL_W must all be >= 1");
  end

  typedef enum logic [1:0] {S_HOLD, S_RUN, S_PASS, S_FAIL} state_t;

  state_t           state, state_nxt;
  logic [HC_W-1:0]  hold_cnt, hold_nxt;
  logic [CNT_W-1:0] cycle_cnt, cycle_nxt;
  logic             dump_en_r, dump_nxt;
  logic [1:0]       reason_r, reason_nxt;
  logic [CH_W-1:0]  chan_r, chan_nxt;
  logic [N_CH-1:0]  mask_r, mask_nxt, mask_acc;
  logic             timeout;
  logic [N_CH-1:0]  stall_mask;

  function automatic logic [CNT_W-1:0] sat_inc_cycle(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [STALL_W-1:0] sat_inc_stall(input logic [STALL_W-1:0] v);
    return (&v) ? v : v + STALL_W'(1);
  endfunction

  function automatic logic [CH_W-1:0] lowest_idx(input logic [N_CH-1:0] m);
    logic [CH_W-1:0] idx;
    idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (m[i]) idx = CH_W'(i);
    end
    return idx;
  endfunction

`ifdef TEST_HARNESS_MONITOR_STALL_EN
  logic [STALL_W-1:0] stall_cnt [N_CH];

  // A channel that has finished or shown progress can never be blamed for a stall.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_CH; i++) stall_cnt[i] <= '0;
    end else if (state == S_HOLD) begin
      for (int i = 0; i < N_CH; i++) stall_cnt[i] <= '0;
    end else if (state == S_RUN) begin
      for (int i = 0; i < N_CH; i++) begin
        if (bus.ch_progress[i] || mask_r[i]) stall_cnt[i] <= '0;
        else                                 stall_cnt[i] <= sat_inc_stall(stall_cnt[i]);
      end
    end
  end

  always_comb begin
    stall_mask = '0;
    for (int i = 0; i < N_CH; i++) begin
      stall_mask[i] = (bus.stall_limit != '0) && !mask_r[i] && (stall_cnt[i] >= bus.stall_limit);
    end
  end
`else
  assign stall_mask = '0;
`endif

  assign mask_acc = mask_r | bus.ch_success;
  assign timeout  = (bus.max_cycles != '0) && (cycle_cnt >= bus.max_cycles);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= S_HOLD;
      hold_cnt  <= '0;
      cycle_cnt <= '0;
      dump_en_r <= 1'b0;
      reason_r  <= 2'd0;
      chan_r    <= '0;
      mask_r    <= '0;
    end else begin
      state     <= state_nxt;
      hold_cnt  <= hold_nxt;
      cycle_cnt <= cycle_nxt;
      dump_en_r <= dump_nxt;
      reason_r  <= reason_nxt;
      chan_r    <= chan_nxt;
      mask_r    <= mask_nxt;
    end
  end

  // Everything is judged against the pre-increment cycle count; terminal states hold all values.
  always_comb begin
    state_nxt  = state;
    hold_nxt   = hold_cnt;
    cycle_nxt  = cycle_cnt;
    dump_nxt   = dump_en_r;
    reason_nxt = reason_r;
    chan_nxt   = chan_r;
    mask_nxt   = mask_r;
    case (state)
      S_HOLD: begin
        hold_nxt  = hold_cnt + HC_W'(1);
        cycle_nxt = sat_inc_cycle(cycle_cnt);
        if (cycle_cnt == bus.dump_start) dump_nxt = 1'b1;
        if (hold_cnt == HOLD_LAST) state_nxt = S_RUN;
      end
      S_RUN: begin
        cycle_nxt = sat_inc_cycle(cycle_cnt);
        mask_nxt  = mask_acc;
        if (cycle_cnt == bus.dump_start) dump_nxt = 1'b1;
        if (|bus.ch_failure) begin
          state_nxt  = S_FAIL;
          reason_nxt = 2'd1;
          chan_nxt   = lowest_idx(bus.ch_failure);
        end else if (timeout) begin
          state_nxt  = S_FAIL;
          reason_nxt = 2'd2;
          chan_nxt   = '0;
        end else if (|stall_mask) begin
          state_nxt  = S_FAIL;
          reason_nxt = 2'd3;
          chan_nxt   = lowest_idx(stall_mask);
        end else if (&mask_acc) begin
          state_nxt = S_PASS;
        end
        if (state_nxt != S_RUN) dump_nxt = 1'b0;
      end
      default: ;
    endcase
  end

  assign bus.dut_reset    = (state == S_HOLD);
  assign bus.cycle_count  = cycle_cnt;
  assign bus.dump_en      = dump_en_r;
  assign bus.pass         = (state == S_PASS);
  assign bus.fail         = (state == S_FAIL);
  assign bus.done         = (state == S_PASS) || (state == S_FAIL);
  assign bus.fail_reason  = reason_r;
  assign bus.fail_channel = chan_r;
  assign bus.done_mask    = mask_r;
endmodule

// File: doc/test_harness_monitor.md
Name: test_harness_monitor

Overview:
- Synthesizable, parametrised end-of-test monitor for simulation and emulation harnesses.
- Sequences the DUT reset and counts cycles.
- Aggregates per-channel success/failure from N_CH sub-harnesses and detects timeout.
- Gates waveform dumping and reports a single terminal pass/fail with a reason code and the offending channel.

Parameters:
- N_CH, 4, number of independent success/failure channels (>=1).
- CNT_W, 64, width of the cycle counter, max_cycles and dump_start.
- RESET_CYCLES, 16, cycles dut_reset is held high after reset release (>=1).
- STALL_W, 16, width of per-channel stall counters and stall_limit (used only with the optional feature).

Ports:
- clock  in  1  single clock for the block.
- reset  in  1  asynchronous, active-low reset.
- max_cycles  in  CNT_W  timeout threshold; 0 disables timeout.
- dump_start  in  CNT_W  cycle_count value at which dumping is enabled.
- ch_success  in  N_CH  per-channel success (level or pulse).
- ch_failure  in  N_CH  per-channel failure (level or pulse).
- dut_reset  out  1  active-high reset driven to the harness/DUT.
- cycle_count  out  CNT_W  cycles elapsed since reset release.
- dump_en  out  1  waveform dump enable.
- done  out  1  terminal state reached.
- pass  out  1  test passed.
- fail  out  1  test failed.
- fail_reason  out  2  0=none, 1=channel failure, 2=timeout, 3=stall.
- fail_channel  out  max(1,$clog2(N_CH))  channel index responsible for the failure.
- done_mask  out  N_CH  sticky record of channels that have reported success.

Behaviour:
- Reset low (async):
  - state=HOLD, hold_cnt=0, cycle_count=0.
  - dut_reset=1; dump_en, done, pass, fail, fail_reason, fail_channel and done_mask all 0.
  - Applies immediately, including mid-RUN or in a terminal state.
- States:
  - HOLD -> RUN -> {PASS | FAIL}.
  - PASS and FAIL are terminal; only reset leaves them.
- HOLD:
  - hold_cnt increments each edge.
  - On the edge where hold_cnt==RESET_CYCLES-1: dut_reset->0 and state->RUN.
  - dut_reset is therefore high for exactly RESET_CYCLES edges after release.
  - All channel inputs are ignored in HOLD.
- cycle_count:
  - Increments on every edge in HOLD and RUN, including the edge that enters PASS/FAIL.
  - Frozen afterwards.
  - Saturates at all-ones (no wrap).
- dump_en:
  - Set on the edge where the pre-increment cycle_count==dump_start and the state is not terminal.
  - Sticky.
  - Cleared on the edge entering PASS/FAIL.
  - If dump_start is never reached, dump_en stays 0.
- RUN, evaluated each edge using the pre-increment cycle_count.
  - done_mask <= done_mask | ch_success.
  - Priority, highest first:
    1. Any ch_failure bit -> FAIL, reason 1, fail_channel = lowest set index.
    2. max_cycles!=0 and cycle_count>=max_cycles -> FAIL, reason 2.
    3. Stall (optional feature) -> FAIL, reason 3.
    4. (done_mask|ch_success)==all-ones -> PASS.
  - Success and failure on the same channel in the same cycle resolve as failure.
  - All channels may succeed in a single cycle.
- Latency:
  - pass/fail/done rise on the edge that samples the qualifying inputs, i.e. they are visible the cycle after the inputs are presented.
  - done=pass|fail.
- Terminal state:
  - All outputs frozen; ch_* inputs ignored.
  - pass and fail are never both 1.
  - For reason 2, fail_channel=0.

Optional Feature:
- Macro: TEST_HARNESS_MONITOR_STALL_EN.
- With the macro defined:
  - Adds input ch_progress [N_CH] and input stall_limit [STALL_W].
  - Each channel has a saturating stall counter, cleared on reset, in HOLD, or when ch_progress[i] or done_mask[i] is set; it increments otherwise in RUN.
  - When stall_limit!=0 and any not-done channel's counter reaches stall_limit: FAIL, reason 3, fail_channel = lowest such index.
  - stall_limit==0 disables the check.
- Without the macro: those ports and counters are absent, and reason 3 is never produced.

Test Plan:
1. Reset low then high, RESET_CYCLES=16 -> dut_reset high for 16 edges, falls with cycle_count=16; all other outputs 0.
2. N_CH=4, max_cycles=0: ch0 success pulse at cycle 30, ch1/ch2 at 40, ch3 at 50 -> done_mask builds up to 4'hF; pass=1, done=1 the next cycle; fail=0; cycle_count frozen at 51.
3. max_cycles=100, no successes -> fail=1, fail_reason=2, cycle_count frozen at 101, dump_en cleared on the same edge.
4. ch_failure=4'b0110 in the cycle timeout would also fire -> fail_reason=1, fail_channel=1; a ch_success on ch2 in that same cycle does not produce pass.
5. dump_start=40 -> dump_en reads 1 when cycle_count reads 41; stays 1 until the terminal edge.
6. Reset asserted at cycle 60 with done_mask=4'b0011 -> done_mask=0 and dut_reset=1 immediately, without waiting for a clock edge. After release, the full HOLD sequence repeats. With STALL_EN, stall_limit=8 and ch2 silent -> fail_reason=3, fail_channel=2.
